// File: rtl/cpu_commit_trace_fifo.sv
// Commit-trace recorder: encodes one trace record per retiring instruction and buffers it in a FIFO.
// Optional drop counter output enabled by defining TRACE_DROP_CNT_EN.
module cpu_commit_trace_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     mips_cpu_clk,
  input  logic                     mips_cpu_reset,
  input  logic                     retire,
  input  logic [31:0]              PC,
  input  logic [31:0]              new_PC,
  input  logic                     is_branch,
  input  logic                     is_link,
  input  logic                     RF_wen,
  input  logic [4:0]               RF_waddr,
  input  logic [31:0]              RF_wdata,
  input  logic                     MemWrite,
  input  logic                     MemRead,
  input  logic [31:0]              Address,
  input  logic [3:0]               Write_strb,
  input  logic [31:0]              Write_data,
  input  logic                     rd_ready,
  input  logic                     clr_ovf,
  output logic                     rd_valid,
  output logic [2:0]               rd_type,
  output logic [31:0]              rd_pc,
  output logic [31:0]              rd_a,
  output logic [31:0]              rd_b,
  output logic [31:0]              rd_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     trace_ovf
`ifdef TRACE_DROP_CNT_EN
  ,
  output logic [15:0]              drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]  typ;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } rec_t;

  // First matching class wins: store, link, non-writing branch, then plain/load.
  function automatic rec_t classify(
    input logic [31:0] pc_i, input logic [31:0] npc_i,
    input logic br_i, input logic lnk_i,
    input logic wen_i, input logic [4:0] waddr_i, input logic [31:0] wdata_i,
    input logic mw_i, input logic mr_i,
    input logic [31:0] addr_i, input logic [3:0] strb_i, input logic [31:0] sdata_i);
    rec_t r;
    r.pc = pc_i;
    if (mw_i) begin
      r.typ = 3'd2;
      r.a   = addr_i;
      r.b   = {28'b0, strb_i};
      r.c   = sdata_i;
    end else if (lnk_i && wen_i) begin
      r.typ = 3'd4;
      r.a   = npc_i;
      r.b   = {27'b0, waddr_i};
      r.c   = wdata_i;
    end else if (br_i && !wen_i) begin
      r.typ = 3'd3;
      r.a   = npc_i;
      r.b   = 32'd0;
      r.c   = 32'd0;
    end else begin
      r.typ = 3'd1;
      r.a   = {27'b0, (wen_i ? waddr_i : 5'd0)};
      r.b   = wen_i ? wdata_i : 32'd0;
      r.c   = {31'b0, mr_i};
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  rec_t        mem [DEPTH];
  rec_t        rec_in;
  rec_t        head;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop, drop;

  assign rec_in = classify(PC, new_PC, is_branch, is_link, RF_wen, RF_waddr, RF_wdata,
                           MemWrite, MemRead, Address, Write_strb, Write_data);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = rd_valid && rd_ready;
  assign push  = retire && (!full || pop);
  assign drop  = retire && full && !pop;

  assign rd_valid = !empty;
  assign count    = wr_ptr - rd_ptr;

  // Head fields are gated so the uninitialised buffer never shows X on the port.
  assign head    = mem[rd_ptr[AW-1:0]];
  assign rd_type = rd_valid ? head.typ : 3'd0;
  assign rd_pc   = rd_valid ? head.pc  : 32'd0;
  assign rd_a    = rd_valid ? head.a   : 32'd0;
  assign rd_b    = rd_valid ? head.b   : 32'd0;
  assign rd_c    = rd_valid ? head.c   : 32'd0;

  always_ff @(posedge mips_cpu_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rec_in;
  end

  always_ff @(posedge mips_cpu_clk or posedge mips_cpu_reset) begin
    if (mips_cpu_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      trace_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // A drop in the same cycle as the clear keeps the flag set.
      if (drop)         trace_ovf <= 1'b1;
      else if (clr_ovf) trace_ovf <= 1'b0;
    end
  end

`ifdef TRACE_DROP_CNT_EN
  always_ff @(posedge mips_cpu_clk or posedge mips_cpu_reset) begin
    if (mips_cpu_reset)  drop_cnt <= 16'd0;
    else if (clr_ovf)    drop_cnt <= drop ? 16'd1 : 16'd0;
    else if (drop)       drop_cnt <= sat_inc16(drop_cnt);
  end
`endif

endmodule

// File: tb/tb_cpu_commit_trace_fifo.sv
// Directed self-checking bench for cpu_commit_trace_fifo (DEPTH=16).
module tb_cpu_commit_trace_fifo;

  logic        mips_cpu_clk = 1'b0;
  logic        mips_cpu_reset;
  logic        retire, is_branch, is_link, RF_wen, MemWrite, MemRead, rd_ready, clr_ovf;
  logic [31:0] PC, new_PC, RF_wdata, Address, Write_data;
  logic [4:0]  RF_waddr;
  logic [3:0]  Write_strb;
  logic        rd_valid, trace_ovf;
  logic [2:0]  rd_type;
  logic [31:0] rd_pc, rd_a, rd_b, rd_c;
  logic [4:0]  count;
`ifdef TRACE_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  cpu_commit_trace_fifo #(.DEPTH(16)) dut (
    .mips_cpu_clk(mips_cpu_clk), .mips_cpu_reset(mips_cpu_reset),
    .retire(retire), .PC(PC), .new_PC(new_PC), .is_branch(is_branch), .is_link(is_link),
    .RF_wen(RF_wen), .RF_waddr(RF_waddr), .RF_wdata(RF_wdata),
    .MemWrite(MemWrite), .MemRead(MemRead),
    .Address(Address), .Write_strb(Write_strb), .Write_data(Write_data),
    .rd_ready(rd_ready), .clr_ovf(clr_ovf),
    .rd_valid(rd_valid), .rd_type(rd_type), .rd_pc(rd_pc),
    .rd_a(rd_a), .rd_b(rd_b), .rd_c(rd_c),
    .count(count), .trace_ovf(trace_ovf)
`ifdef TRACE_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 mips_cpu_clk = ~mips_cpu_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge mips_cpu_clk);
    #1;
  endtask

  task automatic idle();
    retire = 0; PC = 0; new_PC = 0; is_branch = 0; is_link = 0;
    RF_wen = 0; RF_waddr = 0; RF_wdata = 0; MemWrite = 0; MemRead = 0;
    Address = 0; Write_strb = 0; Write_data = 0;
  endtask

  task automatic head(input string tag, input logic [2:0] t, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    check({tag, ".valid"}, {31'b0, rd_valid}, 32'd1);
    check({tag, ".type"},  {29'b0, rd_type},  {29'b0, t});
    check({tag, ".pc"},    rd_pc, pc);
    check({tag, ".a"},     rd_a,  a);
    check({tag, ".b"},     rd_b,  b);
    check({tag, ".c"},     rd_c,  c);
  endtask

  initial begin
    idle();
    rd_ready = 0; clr_ovf = 0;
    mips_cpu_reset = 1;
    #1;
    check("rst.valid", {31'b0, rd_valid}, 32'd0);
    check("rst.count", {27'b0, count}, 32'd0);
    check("rst.ovf",   {31'b0, trace_ovf}, 32'd0);
    check("rst.pc",    rd_pc, 32'd0);
    check("rst.a",     rd_a, 32'd0);
    tick(); tick();
    mips_cpu_reset = 0;
    tick();

    // addiu
    retire = 1; PC = 32'h10; RF_wen = 1; RF_waddr = 5'd8; RF_wdata = 32'h1234;
    tick(); idle();
    head("addiu", 3'd1, 32'h10, 32'd8, 32'h1234, 32'd0);
    check("addiu.count", {27'b0, count}, 32'd1);
    rd_ready = 1; tick(); rd_ready = 0;
    check("addiu.drained", {31'b0, rd_valid}, 32'd0);

    // sw, jal, beq back-to-back while draining
    rd_ready = 1;
    retire = 1; PC = 32'h14; MemWrite = 1; Address = 32'h100; Write_strb = 4'hF;
    Write_data = 32'hDEADBEEF;
    tick(); idle();
    head("sw", 3'd2, 32'h14, 32'h100, 32'hF, 32'hDEADBEEF);
    retire = 1; PC = 32'h20; new_PC = 32'h80; is_link = 1; RF_wen = 1; RF_waddr = 5'd31;
    RF_wdata = 32'h28;
    tick(); idle();
    head("jal", 3'd4, 32'h20, 32'h80, 32'd31, 32'h28);
    check("jal.count", {27'b0, count}, 32'd1);
    retire = 1; PC = 32'h30; new_PC = 32'h40; is_branch = 1;
    tick(); idle();
    head("beq", 3'd3, 32'h30, 32'h40, 32'd0, 32'd0);
    retire = 1; PC = 32'h34; RF_wen = 1; RF_waddr = 5'd9; RF_wdata = 32'h55; MemRead = 1;
    tick(); idle();
    head("lw", 3'd1, 32'h34, 32'd9, 32'h55, 32'd1);
    tick(); rd_ready = 0;
    check("mix.empty", {31'b0, rd_valid}, 32'd0);
    check("mix.count", {27'b0, count}, 32'd0);

    // fill past capacity with no consumer
    for (int i = 0; i < 17; i++) begin
      retire = 1; PC = 32'h1000 + 4 * i; RF_wen = 1; RF_waddr = 5'(i + 1);
      RF_wdata = 32'h100 + i;
      tick();
      if (i == 15) begin
        check("fill16.count", {27'b0, count}, 32'd16);
        check("fill16.ovf", {31'b0, trace_ovf}, 32'd0);
      end
    end
    idle();
    check("ovf.count", {27'b0, count}, 32'd16);
    check("ovf.flag", {31'b0, trace_ovf}, 32'd1);
    head("ovf.head", 3'd1, 32'h1000, 32'd1, 32'h100, 32'd0);
`ifdef TRACE_DROP_CNT_EN
    check("ovf.drop_cnt", {16'b0, drop_cnt}, 32'd1);
`endif

    // drop coinciding with clear keeps the flag
    retire = 1; PC = 32'h3000; clr_ovf = 1;
    tick(); idle();
    check("dropclr.ovf", {31'b0, trace_ovf}, 32'd1);
    check("dropclr.count", {27'b0, count}, 32'd16);
    tick(); clr_ovf = 0;
    check("clr.ovf", {31'b0, trace_ovf}, 32'd0);
`ifdef TRACE_DROP_CNT_EN
    check("clr.drop_cnt", {16'b0, drop_cnt}, 32'd0);
`endif

    // full FIFO: push and pop together
    retire = 1; PC = 32'h2000; RF_wen = 1; RF_waddr = 5'd20; RF_wdata = 32'hABCD; rd_ready = 1;
    tick(); idle(); rd_ready = 0;
    check("fullpp.count", {27'b0, count}, 32'd16);
    check("fullpp.ovf", {31'b0, trace_ovf}, 32'd0);
    check("fullpp.head", rd_pc, 32'h1004);

    // drain in order; held head stays stable first
    tick();
    check("hold.pc", rd_pc, 32'h1004);
    for (int k = 0; k < 16; k++) begin
      if (k < 15) begin
        check("drain.pc", rd_pc, 32'h1004 + 4 * k);
        check("drain.b", rd_b, 32'h101 + k);
      end else begin
        head("tail", 3'd1, 32'h2000, 32'd20, 32'hABCD, 32'd0);
      end
      rd_ready = 1; tick(); rd_ready = 0;
    end
    check("drain.empty", {31'b0, rd_valid}, 32'd0);
    check("drain.count", {27'b0, count}, 32'd0);

    // async reset with records pending
    for (int i = 0; i < 5; i++) begin
      retire = 1; PC = 32'h4000 + 4 * i; tick();
    end
    idle();
    check("pre.count", {27'b0, count}, 32'd5);
    #2 mips_cpu_reset = 1;
    #1;
    check("arst.valid", {31'b0, rd_valid}, 32'd0);
    check("arst.count", {27'b0, count}, 32'd0);
    check("arst.ovf", {31'b0, trace_ovf}, 32'd0);
    check("arst.pc", rd_pc, 32'd0);
    #2 mips_cpu_reset = 0;
    tick();
    check("post.count", {27'b0, count}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
